// File: rtl/regfile_sb_if.sv
// Decode-stage bus of the register file: read ports, write-back, allocation and hazard status.
// The master drives addresses and write-back; the slave (register file) returns data and busy state.
interface regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     hazard;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     alloc_en;
   logic [ADDR_W-1:0]        alloc_addr;
   logic                     flush;
   logic [ADDR_W:0]          busy_count;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
      input  rd_data, rd_busy, hazard, busy_count
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
      output rd_data, rd_busy, hazard, busy_count
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard for RAW hazard detection in decode.
// Reads are combinational with optional write forwarding; writes, busy bits and busy count are clocked.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic         clk,
   input logic         reset,
   regfile_sb_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W:0]   busy_count_q;
   logic [ADDR_W:0]   busy_count_d;

   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_kept;

   function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n = n + {{ADDR_W{1'b0}}, v[i]};
      end
      return n;
   endfunction

   // Write-back into storage; writes to the hardwired zero register are dropped.
   always_comb begin
      regs_d  = regs_q;
      wr_kept = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
      if (wr_kept) begin
         regs_d[bus.wr_addr] = bus.wr_data;
      end else begin
         regs_d = regs_q;
      end
   end

   // Scoreboard update: applying the alloc after the write-back clear lets alloc win on the same address.
   always_comb begin
      busy_d = busy_q;
      if (bus.flush) begin
         busy_d = '0;
      end else begin
         if (bus.wr_en) begin
            busy_d[bus.wr_addr] = 1'b0;
         end else begin
            busy_d = busy_q;
         end
         if (bus.alloc_en) begin
            busy_d[bus.alloc_addr] = 1'b1;
         end else begin
            busy_d = busy_d;
         end
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      busy_count_d = popcount(busy_d);
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   // Read ports; forwarding is suppressed while reset is held so outputs stay at zero.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         logic [ADDR_W-1:0] ra;
         logic              fwd;
         ra  = bus.rd_addr[p*ADDR_W +: ADDR_W];
         fwd = (BYPASS != 0) && reset && bus.wr_en && (bus.wr_addr == ra);
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rd_data[p*DATA_W +: DATA_W] = '0;
            rd_busy[p]                  = 1'b0;
         end else if (fwd) begin
            rd_data[p*DATA_W +: DATA_W] = bus.wr_data;
            rd_busy[p]                  = 1'b0;
         end else begin
            rd_data[p*DATA_W +: DATA_W] = regs_q[ra];
            rd_busy[p]                  = busy_q[ra];
         end
      end
   end

   assign bus.rd_data    = rd_data;
   assign bus.rd_busy    = rd_busy;
   assign bus.hazard     = |rd_busy;
   assign bus.busy_count = busy_count_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb: two instances (forwarding + zero register, and neither)
// share one stimulus stream and are compared against an array-based model of the register file.
module tb_regfile_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 1 << AW;

   logic clk;
   logic reset;

   logic [NR*AW-1:0] rd_addr;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             alloc_en;
   logic [AW-1:0]    alloc_addr;
   logic             flush;

   int n_checks = 0;
   int n_errors = 0;

   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ifa ();
   regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) ifb ();

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1))
      dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0))
      dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

   assign ifa.rd_addr = rd_addr;    assign ifb.rd_addr = rd_addr;
   assign ifa.wr_en = wr_en;        assign ifb.wr_en = wr_en;
   assign ifa.wr_addr = wr_addr;    assign ifb.wr_addr = wr_addr;
   assign ifa.wr_data = wr_data;    assign ifb.wr_data = wr_data;
   assign ifa.alloc_en = alloc_en;  assign ifb.alloc_en = alloc_en;
   assign ifa.alloc_addr = alloc_addr; assign ifb.alloc_addr = alloc_addr;
   assign ifa.flush = flush;        assign ifb.flush = flush;

   logic [NR*DW-1:0] got_data  [2];
   logic [NR-1:0]    got_busy  [2];
   logic             got_haz   [2];
   logic [AW:0]      got_count [2];
   assign got_data[0] = ifa.rd_data;     assign got_data[1] = ifb.rd_data;
   assign got_busy[0] = ifa.rd_busy;     assign got_busy[1] = ifb.rd_busy;
   assign got_haz[0] = ifa.hazard;       assign got_haz[1] = ifb.hazard;
   assign got_count[0] = ifa.busy_count; assign got_count[1] = ifb.busy_count;

   // Reference model: configuration 0 has a zero register and forwarding, configuration 1 has neither.
   bit          cfg_zero [2] = '{1'b1, 1'b0};
   bit          cfg_byp  [2] = '{1'b1, 1'b0};
   logic [DW-1:0] mem  [2][DEPTH];
   bit            busy [2][DEPTH];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input int c, input logic [AW-1:0] a);
      if (!reset) return '0;
      if (cfg_zero[c] && a == 0) return '0;
      if (cfg_byp[c] && wr_en && wr_addr == a) return wr_data;
      return mem[c][a];
   endfunction

   function automatic bit exp_busy(input int c, input logic [AW-1:0] a);
      if (!reset) return 1'b0;
      if (cfg_zero[c] && a == 0) return 1'b0;
      if (cfg_byp[c] && wr_en && wr_addr == a) return 1'b0;
      return busy[c][a];
   endfunction

   function automatic int exp_count(input int c);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += busy[c][i] ? 1 : 0;
      return n;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++)
         for (int i = 0; i < DEPTH; i++) begin
            mem[c][i]  = '0;
            busy[c][i] = 1'b0;
         end
   endtask

   task automatic model_edge();
      if (!reset) begin
         model_reset();
         return;
      end
      for (int c = 0; c < 2; c++) begin
         if (wr_en && !(cfg_zero[c] && wr_addr == 0)) mem[c][wr_addr] = wr_data;
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) busy[c][i] = 1'b0;
         end else if (alloc_en && wr_en && alloc_addr == wr_addr) begin
            busy[c][alloc_addr] = 1'b1;
         end else begin
            if (wr_en) busy[c][wr_addr] = 1'b0;
            if (alloc_en) busy[c][alloc_addr] = 1'b1;
         end
         if (cfg_zero[c]) busy[c][0] = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int c = 0; c < 2; c++) begin
         bit any_busy = 1'b0;
         for (int p = 0; p < NR; p++) begin
            logic [AW-1:0] a;
            a = rd_addr[p*AW +: AW];
            check_val($sformatf("%s_d%0d_p%0d_data", tag, c, p), 64'(got_data[c][p*DW +: DW]), 64'(exp_data(c, a)));
            check_val($sformatf("%s_d%0d_p%0d_busy", tag, c, p), 64'(got_busy[c][p]), 64'(exp_busy(c, a)));
            any_busy |= exp_busy(c, a);
         end
         check_val($sformatf("%s_d%0d_hazard", tag, c), 64'(got_haz[c]), 64'(any_busy));
         check_val($sformatf("%s_d%0d_count", tag, c), 64'(got_count[c]), 64'(exp_count(c)));
      end
   endtask

   task automatic set_idle();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
   endtask

   task automatic step(input string tag);
      @(negedge clk);
      check_outputs(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      reset = 1'b0;
      rd_addr = '0;
      set_idle();
      model_reset();
      #12;
      check_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = {AW'(a), AW'(a)};
         step("rd_all");
      end

      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd0};
      step("wr_r0");
      set_idle(); #1;
      check_val("r0_reads_zero", 64'(ifa.rd_data[31:0]), 64'h0);
      step("rd_r0");

      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; rd_addr = {5'd0, 5'd5}; #1;
      check_val("bypass_same_cycle", 64'(ifa.rd_data[31:0]), 64'h12345678);
      check_val("nobypass_same_cycle", 64'(ifb.rd_data[31:0]), 64'h0);
      step("wr_r5");
      set_idle(); #1;
      check_val("nobypass_next_cycle", 64'(ifb.rd_data[31:0]), 64'h12345678);
      step("rd_r5");

      alloc_en = 1'b1; alloc_addr = 5'd7;
      step("alloc_r7");
      set_idle(); rd_addr = {5'd7, 5'd0}; #1;
      check_val("r7_busy", 64'(ifa.rd_busy[1]), 64'h1);
      check_val("r7_hazard", 64'(ifa.hazard), 64'h1);
      check_val("r7_count", 64'(ifa.busy_count), 64'h1);
      step("rd_r7");
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5; #1;
      check_val("r7_wb_busy", 64'(ifa.rd_busy[1]), 64'h0);
      check_val("r7_wb_data", 64'(ifa.rd_data[63:32]), 64'hA5);
      step("wb_r7");
      set_idle(); #1;
      check_val("r7_count_clear", 64'(ifa.busy_count), 64'h0);
      step("post_r7");

      alloc_en = 1'b1; alloc_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
      step("alloc_wr_r9");
      set_idle(); rd_addr = {5'd0, 5'd9}; #1;
      check_val("r9_data", 64'(ifa.rd_data[31:0]), 64'h55);
      check_val("r9_busy", 64'(ifa.rd_busy[0]), 64'h1);
      check_val("r9_count", 64'(ifa.busy_count), 64'h1);
      step("rd_r9");

      for (int r = 1; r <= 3; r++) begin
         alloc_en = 1'b1; alloc_addr = AW'(r);
         step("alloc_seq");
      end
      alloc_en = 1'b1; alloc_addr = 5'd4; flush = 1'b1;
      step("flush");
      set_idle(); rd_addr = {5'd4, 5'd5}; #1;
      check_val("flush_count", 64'(ifa.busy_count), 64'h0);
      check_val("flush_hazard", 64'(ifa.hazard), 64'h0);
      check_val("flush_keeps_r5", 64'(ifa.rd_data[31:0]), 64'h12345678);
      step("post_flush");

      alloc_en = 1'b1; alloc_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
      rd_addr = {5'd3, 5'd5};
      @(posedge clk); model_edge();
      #3; reset = 1'b0; model_reset(); #1;
      check_val("async_rst_count", 64'(ifa.busy_count), 64'h0);
      check_val("async_rst_data", 64'(ifa.rd_data), 64'h0);
      check_outputs("async_rst");
      step("in_reset");
      reset = 1'b1; set_idle();
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1;
      step("wr_r3");
      set_idle(); #1;
      check_val("r3_after_reset", 64'(ifa.rd_data[63:32]), 64'h1);
      check_val("r3_after_reset_b", 64'(ifb.rd_data[63:32]), 64'h1);
      step("rd_r3");

      for (int it = 0; it < 1500; it++) begin
         logic [AW-1:0] ra0, ra1;
         bit narrow;
         narrow = ($urandom_range(0, 3) != 0);
         ra0 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
         ra1 = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
         rd_addr    = {ra1, ra0};
         wr_en      = $urandom_range(0, 1) == 1;
         wr_addr    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
         wr_data    = $urandom;
         alloc_en   = $urandom_range(0, 2) != 0;
         alloc_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
         flush      = $urandom_range(0, 31) == 0;
         if (it == 700) begin
            #2; reset = 1'b0; model_reset(); #1;
            check_outputs("rand_rst");
         end else if (it == 703) begin
            reset = 1'b1;
         end
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
